// File: rtl/lcd_bus_ctrl.sv
// HD44780-style character-LCD bus controller: queued {rs,rwb,data} commands become
// E/RS/RW/DB bus cycles with tick-based phase timing, in 8-bit or 4-bit bus mode.
module lcd_bus_ctrl #(
  parameter int CLK_DIV    = 16,
  parameter int T_AS       = 1,
  parameter int T_PW       = 4,
  parameter int T_H        = 4,
  parameter int T_SETTLE   = 2,
  parameter int BUS4       = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic       cmd_rwb,
  input  logic [7:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic [7:0] lcd_db_out,
  input  logic [7:0] lcd_db_in,
  output logic       lcd_db_oe,
  output logic       lcd_rs,
  output logic       lcd_rwb,
  output logic       lcd_e,
  output logic [2:0] dbg_state
);

  localparam int  AW = $clog2(FIFO_DEPTH);
  localparam int  PW = $clog2(CLK_DIV);
  localparam bit  B4 = (BUS4 != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_EN     = 3'd2,
    S_HOLD   = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  logic [PW-1:0] presc;
  logic [15:0]   tcnt, n_lim;
  logic          tick, done, entry;
  logic          rs_r, rwb_r, second;
  logic [7:0]    data_r;
  logic [3:0]    rd_hi;

  // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on FIFO occupancy, never on cmd_valid.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == S_IDLE) && !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_rs, cmd_rwb, cmd_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign tick = (presc == PW'(CLK_DIV - 1));

  always_comb begin
    n_lim = 16'd0;
    case (state)
      S_SETUP:  n_lim = 16'(T_AS - 1);
      S_EN:     n_lim = 16'(T_PW - 1);
      S_HOLD:   n_lim = 16'(T_H - 1);
      S_SETTLE: n_lim = 16'(T_SETTLE - 1);
      default:  n_lim = 16'd0;
    endcase
  end

  assign done = (state != S_IDLE) && tick && (tcnt == n_lim);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!empty) state_nx = S_SETUP;
      S_SETUP:  if (done)   state_nx = S_EN;
      S_EN:     if (done)   state_nx = S_HOLD;
      S_HOLD:   if (done)   state_nx = (B4 && !second) ? S_SETUP : S_SETTLE;
      S_SETTLE: if (done)   state_nx = S_IDLE;
      default:              state_nx = S_IDLE;
    endcase
  end

  // Every transition changes state, so a state change marks a phase entry.
  assign entry = (state_nx != state);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      presc <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      if (entry) begin
        presc <= '0;
        tcnt  <= '0;
      end else if (state != S_IDLE) begin
        if (tick) begin
          presc <= '0;
          tcnt  <= tcnt + 16'd1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rs_r     <= 1'b0;
      rwb_r    <= 1'b0;
      data_r   <= 8'h00;
      second   <= 1'b0;
      rd_hi    <= 4'h0;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (pop) begin
        {rs_r, rwb_r, data_r} <= mem[rd_ptr[AW-1:0]];
        second <= 1'b0;
      end
      if (state == S_HOLD && state_nx == S_SETUP) second <= 1'b1;
      // Read data is taken on the last EN clk; the result lands as HOLD begins.
      if (state == S_EN && done && rwb_r) begin
        if (B4 && !second) begin
          rd_hi <= lcd_db_in[7:4];
        end else begin
          rd_data  <= B4 ? {rd_hi, lcd_db_in[7:4]} : lcd_db_in;
          rd_valid <= 1'b1;
        end
      end
    end
  end

  assign lcd_e      = (state == S_EN);
  assign lcd_db_oe  = !rwb_r && (state == S_SETUP || state == S_EN || state == S_HOLD);
  assign lcd_db_out = B4 ? {(second ? data_r[3:0] : data_r[7:4]), 4'h0} : data_r;
  assign lcd_rs     = rs_r;
  assign lcd_rwb    = rwb_r;
  assign busy       = (state != S_IDLE) || !empty;
  assign dbg_state  = state;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// Directed bench for lcd_bus_ctrl: one 8-bit instance (a_) and one 4-bit instance (b_),
// both with CLK_DIV=4, T_AS=1, T_PW=2, T_H=2, T_SETTLE=1, FIFO_DEPTH=4.
module tb_lcd_bus_ctrl;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  logic       a_valid, a_ready, a_rs, a_rwb, a_rd_valid, a_busy, a_oe, a_lrs, a_lrwb, a_e;
  logic [7:0] a_data, a_rd_data, a_db_out, a_db_in;
  logic [2:0] a_dbg;
  logic       b_valid, b_ready, b_rs, b_rwb, b_rd_valid, b_busy, b_oe, b_lrs, b_lrwb, b_e;
  logic [7:0] b_data, b_rd_data, b_db_out, b_db_in;
  logic [2:0] b_dbg;

  logic [9:0] a_exp_q[$], a_obs_q[$], b_exp_q[$], b_obs_q[$];
  int         a_pulses = 0;
  logic       a_e_prev = 1'b0, b_e_prev = 1'b0;

  always #5 clk = ~clk;

  lcd_bus_ctrl #(.CLK_DIV(4), .T_AS(1), .T_PW(2), .T_H(2), .T_SETTLE(1), .BUS4(0), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rstn(rstn), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_rs(a_rs),
    .cmd_rwb(a_rwb), .cmd_data(a_data), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .busy(a_busy), .lcd_db_out(a_db_out), .lcd_db_in(a_db_in), .lcd_db_oe(a_oe),
    .lcd_rs(a_lrs), .lcd_rwb(a_lrwb), .lcd_e(a_e), .dbg_state(a_dbg));

  lcd_bus_ctrl #(.CLK_DIV(4), .T_AS(1), .T_PW(2), .T_H(2), .T_SETTLE(1), .BUS4(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rstn(rstn), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_rs(b_rs),
    .cmd_rwb(b_rwb), .cmd_data(b_data), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .busy(b_busy), .lcd_db_out(b_db_out), .lcd_db_in(b_db_in), .lcd_db_oe(b_oe),
    .lcd_rs(b_lrs), .lcd_rwb(b_lrwb), .lcd_e(b_e), .dbg_state(b_dbg));

  // Bus monitor: record {rs,rwb,db} at every E rise
  always @(negedge clk) begin
    if (a_e && !a_e_prev) begin
      a_obs_q.push_back({a_lrs, a_lrwb, a_db_out});
      a_pulses++;
    end
    if (b_e && !b_e_prev) b_obs_q.push_back({b_lrs, b_lrwb, b_db_out});
    a_e_prev = a_e;
    b_e_prev = b_e;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a_queue(input string tag);
    chk({tag, "_count"}, a_obs_q.size(), a_exp_q.size());
    for (int i = 0; i < a_exp_q.size() && i < a_obs_q.size(); i++)
      chk({tag, "_item"}, a_obs_q[i], a_exp_q[i]);
  endtask

  task automatic chk_b_queue(input string tag);
    chk({tag, "_count"}, b_obs_q.size(), b_exp_q.size());
    for (int i = 0; i < b_exp_q.size() && i < b_obs_q.size(); i++)
      chk({tag, "_item"}, b_obs_q[i], b_exp_q[i]);
  endtask

  task automatic drain_a(input string tag);
    int n = 0;
    while (a_busy && n < 400) begin step(1); n++; end
    chk(tag, a_busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d4 [6];
    int         p_at_rst;
    d4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rstn = 1'b0;
    a_valid = 0; a_rs = 0; a_rwb = 0; a_data = 8'h00; a_db_in = 8'h00;
    b_valid = 0; b_rs = 0; b_rwb = 0; b_data = 8'h00; b_db_in = 8'h00;

    // Reset state
    step(3);
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_e", a_e, 1'b0);
    chk("rst_oe", a_oe, 1'b0);
    chk("rst_rs_rw", {a_lrs, a_lrwb}, 2'b00);
    chk("rst_db", a_db_out, 8'h00);
    chk("rst_rd", {a_rd_valid, a_rd_data}, 9'h000);
    chk("rst_dbg", a_dbg, 3'd0);
    chk("rst_b_ready", b_ready, 1'b1);
    rstn = 1'b1;
    step(2);

    // T1: 8-bit write rs=0 data=0x38
    a_valid = 1; a_rs = 0; a_rwb = 0; a_data = 8'h38;
    chk("t1_ready", a_ready, 1'b1);
    step(1); a_valid = 0;                           // cycle 1
    chk("t1_busy_c1", a_busy, 1'b1);
    step(1);                                         // cycle 2
    chk("t1_db_c2", a_db_out, 8'h38);
    chk("t1_oe_c2", a_oe, 1'b1);
    chk("t1_rs_c2", a_lrs, 1'b0);
    chk("t1_e_c2", a_e, 1'b0);
    step(3); chk("t1_e_c5", a_e, 1'b0);
    step(1); chk("t1_e_c6", a_e, 1'b1);
    step(7); chk("t1_e_c13", a_e, 1'b1);
    chk("t1_db_c13", a_db_out, 8'h38);
    step(1); chk("t1_e_c14", a_e, 1'b0);
    chk("t1_oe_c14", a_oe, 1'b1);
    step(8); chk("t1_oe_c22", a_oe, 1'b0);
    chk("t1_busy_c22", a_busy, 1'b1);
    step(3); chk("t1_busy_c25", a_busy, 1'b1);
    step(1); chk("t1_busy_c26", a_busy, 1'b0);

    // T2: 4-bit write rs=1 data=0xA5
    b_obs_q.delete(); b_exp_q.delete();
    b_exp_q.push_back({1'b1, 1'b0, 8'hA0});
    b_exp_q.push_back({1'b1, 1'b0, 8'h50});
    b_valid = 1; b_rs = 1; b_rwb = 0; b_data = 8'hA5;
    step(1); b_valid = 0;
    step(1); chk("t2_db_c2", b_db_out, 8'hA0);
    chk("t2_rs_c2", b_lrs, 1'b1);
    step(4); chk("t2_e_c6", b_e, 1'b1);
    step(8); chk("t2_e_c14", b_e, 1'b0);
    step(8); chk("t2_e_c22", b_e, 1'b0);
    chk("t2_db_c22", b_db_out, 8'h50);
    chk("t2_oe_c22", b_oe, 1'b1);
    step(4); chk("t2_e_c26", b_e, 1'b1);
    chk("t2_rs_c26", b_lrs, 1'b1);
    step(8); chk("t2_e_c34", b_e, 1'b0);
    step(8); chk("t2_oe_c42", b_oe, 1'b0);
    chk("t2_busy_c42", b_busy, 1'b1);
    step(3); chk("t2_busy_c45", b_busy, 1'b1);
    step(1); chk("t2_busy_c46", b_busy, 1'b0);
    chk_b_queue("t2_bus");

    // T3a: 8-bit read with DB=0x80
    a_db_in = 8'h80;
    a_valid = 1; a_rs = 0; a_rwb = 1; a_data = 8'hFF;
    step(1); a_valid = 0;
    step(1); chk("t3_oe_c2", a_oe, 1'b0);
    chk("t3_rwb_c2", a_lrwb, 1'b1);
    step(6); chk("t3_e_c8", a_e, 1'b1);
    chk("t3_oe_c8", a_oe, 1'b0);
    step(5); chk("t3_rdv_c13", a_rd_valid, 1'b0);
    step(1); chk("t3_rdv_c14", a_rd_valid, 1'b1);
    chk("t3_rdd_c14", a_rd_data, 8'h80);
    step(1); chk("t3_rdv_c15", a_rd_valid, 1'b0);
    chk("t3_rdd_c15", a_rd_data, 8'h80);
    step(11); chk("t3_busy_c26", a_busy, 1'b0);

    // T3b: 4-bit read, nibbles 0x8 then 0x3 (low DB bits must be ignored)
    b_db_in = 8'h8C;
    b_valid = 1; b_rs = 0; b_rwb = 1; b_data = 8'h00;
    step(1); b_valid = 0;
    step(1); chk("t3b_oe_c2", b_oe, 1'b0);
    step(12); chk("t3b_rdv_c14", b_rd_valid, 1'b0);
    chk("t3b_rdd_c14", b_rd_data, 8'h00);
    step(6); b_db_in = 8'h35;                      // cycle 20
    step(13); chk("t3b_rdv_c33", b_rd_valid, 1'b0);
    step(1); chk("t3b_rdv_c34", b_rd_valid, 1'b1);
    chk("t3b_rdd_c34", b_rd_data, 8'h83);
    step(1); chk("t3b_rdv_c35", b_rd_valid, 1'b0);
    step(11); chk("t3b_busy_c46", b_busy, 1'b0);

    // T4: six back-to-back pushes from idle
    a_obs_q.delete(); a_exp_q.delete();
    for (int i = 0; i < 6; i++) a_exp_q.push_back({i[0], 1'b0, d4[i]});
    a_rwb = 0;
    for (int i = 0; i < 5; i++) begin            // cycles 0..4
      a_valid = 1; a_rs = i[0]; a_data = d4[i];
      chk("t4_ready_early", a_ready, 1'b1);
      if (i == 2) chk("t4_db_c2", a_db_out, d4[0]);
      step(1);
    end
    a_rs = 1; a_data = d4[5];                     // cycle 5
    chk("t4_ready_c5", a_ready, 1'b0);
    step(21); chk("t4_ready_c26", a_ready, 1'b0);
    chk("t4_db_c26", a_db_out, d4[0]);
    step(1); chk("t4_ready_c27", a_ready, 1'b1);
    chk("t4_db_c27", a_db_out, d4[1]);
    step(1); a_valid = 0;
    drain_a("t4_drain");
    chk_a_queue("t4_bus");

    // T5: reset in the middle of EN with three entries queued
    for (int i = 0; i < 4; i++) begin
      a_valid = 1; a_rs = 0; a_data = 8'(i + 1);
      step(1);
    end
    a_valid = 0;                                   // cycle 4
    step(4); chk("t5_e_c8", a_e, 1'b1);
    #2 rstn = 1'b0;
    #1 chk("t5_e_async", a_e, 1'b0);
    chk("t5_ready_rst", a_ready, 1'b1);
    chk("t5_busy_rst", a_busy, 1'b0);
    p_at_rst = a_pulses;
    step(2);
    #2 rstn = 1'b1;
    step(100);
    chk("t5_pulses", a_pulses, p_at_rst);
    chk("t5_busy", a_busy, 1'b0);
    chk("t5_ready", a_ready, 1'b1);

    // T6: push on the last SETTLE cycle
    a_valid = 1; a_rs = 0; a_data = 8'h5A;
    step(1); a_valid = 0;
    step(21);                                      // cycle 22
    for (int i = 0; i < 4; i++) begin
      chk("t6_e_settle", a_e, 1'b0);
      if (i == 3) begin
        a_valid = 1; a_data = 8'hC3;
        chk("t6_ready_c25", a_ready, 1'b1);
      end
      step(1);
    end
    a_valid = 0;                                   // cycle 26
    chk("t6_busy_c26", a_busy, 1'b1);
    chk("t6_dbg_c26", a_dbg, 3'd0);
    chk("t6_db_c26", a_db_out, 8'h5A);
    step(1); chk("t6_dbg_c27", a_dbg, 3'd1);
    chk("t6_db_c27", a_db_out, 8'hC3);
    step(3); chk("t6_e_c30", a_e, 1'b0);
    step(1); chk("t6_e_c31", a_e, 1'b1);
    drain_a("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
